// File: rtl/trig_counter_param.sv
// ---------------------------------------------------------------------------
// trig_counter_param
//
// Generic trigger-driven event counter. Counts trigger events (level or
// rising-edge qualified) up or down over the range 0..MAX_VAL, wrapping or
// saturating at the limits. Supports synchronous clear and load. All outputs
// are registered, so there is no combinational path from any input to any
// output.
//
// Parameters:
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   highest count value, must fit in WIDTH bits
//   EDGE_MODE 0: count every clock trig is high; 1: count trig 0->1 only
//   SATURATE  0: wrap at the range limits; 1: hold at the range limits
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   trig      count request
//   dir       1 = count up, 0 = count down (sampled with the event)
//   load      synchronous load strobe
//   load_val  value to load, clamped to MAX_VAL
//   clr       synchronous clear of count and ovf
//   out       registered binary count
//   gray_out  registered Gray code of the count, aligned with out
//   tc        one-cycle pulse on a wrap or saturation hit
//   ovf       sticky flag, set on any wrap or saturation hit
//
// Handshake: there is no valid/ready pairing; every input is sampled on each
// rising clk edge and its effect is visible on the outputs one cycle later.
// Priority on a given edge is clr > load > count event > hold.
// ---------------------------------------------------------------------------
module trig_counter_param #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     EDGE_MODE = 0,
    parameter int unsigned     SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] LIMIT = MAX_VAL[WIDTH-1:0];

    logic             trig_d;
    logic             ev;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_out;
    logic [WIDTH-1:0] next_gray;
    logic             next_tc;
    logic             next_ovf;

    // In edge mode a held-high trig yields exactly one event; trig_d is
    // tracked every cycle regardless of clr/load so an edge coinciding with
    // a load is consumed (dropped) rather than deferred.
    assign ev = (EDGE_MODE != 0) ? (trig & ~trig_d) : trig;

    assign load_clamped = (load_val > LIMIT) ? LIMIT : load_val;

    always_comb begin
        next_out = out;
        next_tc  = 1'b0;
        next_ovf = ovf;
        if (clr) begin
            next_out = '0;
            next_ovf = 1'b0;
        end else if (load) begin
            next_out = load_clamped;
        end else if (ev) begin
            if (dir) begin
                if (out == LIMIT) begin
                    next_out = (SATURATE != 0) ? LIMIT : '0;
                    next_tc  = 1'b1;
                    next_ovf = 1'b1;
                end else begin
                    next_out = out + 1'b1;
                end
            end else begin
                if (out == '0) begin
                    next_out = (SATURATE != 0) ? '0 : LIMIT;
                    next_tc  = 1'b1;
                    next_ovf = 1'b1;
                end else begin
                    next_out = out - 1'b1;
                end
            end
        end
        // Gray is derived from the next count so it lands on the same edge
        // as out, with no skew between the two.
        next_gray = next_out ^ (next_out >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= '0;
            gray_out <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
            trig_d   <= 1'b0;
        end else begin
            out      <= next_out;
            gray_out <= next_gray;
            tc       <= next_tc;
            ovf      <= next_ovf;
            trig_d   <= trig;
        end
    end

endmodule

// File: doc/trig_counter_param.md
Name: trig_counter_param

Overview:
Parametrised successor to the 4-bit trigger-driven binary counter. Counts trigger events in level or rising-edge mode, up or down, with a programmable modulus, wrap or saturate, synchronous load and clear. Provides registered binary and Gray outputs, a terminal-count pulse and a sticky overflow flag. Used as a generic event and sequence counter in the project datapaths.

Parameters:
WIDTH, 4, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, highest count value; counter range is 0..MAX_VAL; must be <= 2**WIDTH-1
EDGE_MODE, 0, 0 = count every clock trig is high; 1 = count only on a 0->1 transition of trig
SATURATE, 0, 0 = wrap at the range limits; 1 = hold at the range limits

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
trig  input  1  count request (synchronous to clk)
dir  input  1  1 = up, 0 = down; sampled together with the count event
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load; clamped to MAX_VAL
clr  input  1  synchronous clear of the count and ovf
out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray code of the count, same cycle as out
tc  output  1  one-cycle pulse when a wrap or saturation hit occurs
ovf  output  1  sticky flag, set on any wrap or saturation hit

Behaviour:
- Reset (rst=1, asynchronous): out=0, gray_out=0, tc=0, ovf=0, internal trig_d=0. Reset holds while asserted. Reset asserted mid-count aborts the count immediately, with no tc pulse.
- Count event (ev):
  - EDGE_MODE=0: ev = trig.
  - EDGE_MODE=1: ev = trig & ~trig_d. trig_d is registered every cycle, including cycles with load or clr.
  - trig held high in EDGE_MODE=1 gives exactly one count.
- Priority per clock: clr > load > ev. Otherwise hold.
- clr: out=0, ovf=0, tc=0.
- load: out = min(load_val, MAX_VAL). ovf is unchanged. tc=0. A simultaneous ev is ignored.
- ev, dir=1:
  - out < MAX_VAL: out+1.
  - out == MAX_VAL: out=0 if SATURATE=0, else hold MAX_VAL. In both cases tc=1 and ovf=1.
- ev, dir=0:
  - out > 0: out-1.
  - out == 0: out=MAX_VAL if SATURATE=0, else hold 0. In both cases tc=1 and ovf=1.
- tc is high for exactly the one cycle following the causing edge, and is 0 otherwise. Repeated saturation hits pulse tc on every hit.
- gray_out = next_out ^ (next_out >> 1). It is registered in the same edge as out, so there is zero skew between the two.
- Latency: one clock from a sampled ev, load or clr to a visible out change.
- No combinational path from any input to any output.
- Arithmetic is WIDTH bits. MAX_VAL comparisons use the full width. There is no internal overflow beyond WIDTH.

Test Plan:
1. WIDTH=4 defaults; rst high 10 ns then low; trig=1 for 7 clocks, then 0 for 7 clocks -> out steps 1..7 and holds 7; gray_out=4'b0100 at 7; tc=0; ovf=0.
2. Defaults, dir=1; trig=1 for 17 clocks from 0 -> out reaches 15, wraps to 0 with tc=1 for one cycle, ends at 1; ovf=1 sticky. Then clr -> out=0, ovf=0.
3. MAX_VAL=9, SATURATE=1, dir=0; load load_val=12 -> out=9. Then trig=1 for 11 clocks -> out counts down to 0, then tc pulses on each of the last 2 cycles while holding 0; ovf=1.
4. EDGE_MODE=1; trig high 5 clocks, low 2, high 1 -> out=2. Also trig rising in the same cycle as load load_val=3 -> out=3 (the event is dropped).
5. Simultaneous clr, load and trig at out=6 -> out=0. Then rst pulsed asynchronously between clock edges at out=5 -> out, gray_out, tc and ovf all 0 immediately, before the next clk edge.
